// File: rtl/param_reservation_station.sv
// ----------------------------------------------------------------------------
// param_reservation_station
// DEPTH-entry reservation station for the Tomasulo ALU path. Holds issued ALU
// instructions until both operands are valid, snooping NUM_CDB common data
// buses to resolve pending operands, and dispatches the lowest-index ready
// entry to the ALU through a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_flush                  synchronous clear of all entries
//   i_issue_*, o_issue_ready issue interface from the decoder/issue stage
//   i_cdb_valid/tag/data     packed CDB channels, channel 0 in the LSBs
//   o_exec_*, i_exec_ready   dispatch interface to the ALU
//   o_count                  number of occupied entries
// ----------------------------------------------------------------------------
module param_reservation_station #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = 3,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_CDB = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_flush,
   input  logic                        i_issue_valid,
   output logic                        o_issue_ready,
   input  logic [2:0]                  i_issue_op,
   input  logic [WIDTH-1:0]            i_issue_vj,
   input  logic [WIDTH-1:0]            i_issue_vk,
   input  logic [TAG_W-1:0]            i_issue_qj,
   input  logic [TAG_W-1:0]            i_issue_qk,
   input  logic                        i_issue_rdy_j,
   input  logic                        i_issue_rdy_k,
   input  logic [TAG_W-1:0]            i_issue_dest,
   input  logic [NUM_CDB-1:0]          i_cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]    i_cdb_tag,
   input  logic [NUM_CDB*WIDTH-1:0]    i_cdb_data,
   output logic                        o_exec_valid,
   input  logic                        i_exec_ready,
   output logic [2:0]                  o_exec_op,
   output logic [WIDTH-1:0]            o_exec_vj,
   output logic [WIDTH-1:0]            o_exec_vk,
   output logic [TAG_W-1:0]            o_exec_dest,
   output logic [$clog2(DEPTH+1)-1:0]  o_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   // Entry storage
   logic              r_busy [DEPTH];
   logic [2:0]        r_op   [DEPTH];
   logic [WIDTH-1:0]  r_vj   [DEPTH];
   logic [WIDTH-1:0]  r_vk   [DEPTH];
   logic [TAG_W-1:0]  r_qj   [DEPTH];
   logic [TAG_W-1:0]  r_qk   [DEPTH];
   logic              r_rj   [DEPTH];
   logic              r_rk   [DEPTH];
   logic [TAG_W-1:0]  r_dest [DEPTH];
   logic [CNT_W-1:0]  r_count;

   // {hit, data} lookup across all CDB channels; lowest channel index wins.
   function automatic logic [WIDTH:0] cdb_lookup(
      input logic [TAG_W-1:0]         tag,
      input logic [NUM_CDB-1:0]       vld,
      input logic [NUM_CDB*TAG_W-1:0] tags,
      input logic [NUM_CDB*WIDTH-1:0] data
   );
      logic [WIDTH:0] res;
      res = '0;
      for (int unsigned c = 0; c < NUM_CDB; c++) begin
         if (!res[WIDTH] && vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
            res = {1'b1, data[c*WIDTH +: WIDTH]};
         end
      end
      return res;
   endfunction

   logic [WIDTH:0]    w_snp_j [DEPTH];
   logic [WIDTH:0]    w_snp_k [DEPTH];
   logic [WIDTH:0]    w_byp_j;
   logic [WIDTH:0]    w_byp_k;
   logic              w_alloc_found;
   logic [IDX_W-1:0]  w_alloc_idx;
   logic              w_disp_found;
   logic [IDX_W-1:0]  w_disp_idx;
   logic              w_issue_fire;
   logic              w_disp_fire;

   // Issue readiness comes from the registered count only: no full bypass.
   assign o_issue_ready = (r_count < CNT_W'(DEPTH));
   assign w_issue_fire  = i_issue_valid && o_issue_ready;
   assign w_disp_fire   = o_exec_valid && i_exec_ready;
   assign o_count       = r_count;

   assign w_byp_j = cdb_lookup(i_issue_qj, i_cdb_valid, i_cdb_tag, i_cdb_data);
   assign w_byp_k = cdb_lookup(i_issue_qk, i_cdb_valid, i_cdb_tag, i_cdb_data);

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_snp_j[i] = cdb_lookup(r_qj[i], i_cdb_valid, i_cdb_tag, i_cdb_data);
         w_snp_k[i] = cdb_lookup(r_qk[i], i_cdb_valid, i_cdb_tag, i_cdb_data);
      end
   end

   // Allocation uses the registered busy vector, so an entry freed this cycle
   // is not reused until the next one.
   always_comb begin
      w_alloc_found = 1'b0;
      w_alloc_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!w_alloc_found && !r_busy[i]) begin
            w_alloc_found = 1'b1;
            w_alloc_idx   = IDX_W'(i);
         end
      end
   end

   // Readiness is purely registered state, so a snooped operand becomes
   // dispatchable one cycle after its broadcast.
   always_comb begin
      w_disp_found = 1'b0;
      w_disp_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!w_disp_found && r_busy[i] && r_rj[i] && r_rk[i]) begin
            w_disp_found = 1'b1;
            w_disp_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      o_exec_valid = w_disp_found;
      o_exec_op    = '0;
      o_exec_vj    = '0;
      o_exec_vk    = '0;
      o_exec_dest  = '0;
      if (w_disp_found) begin
         o_exec_op   = r_op[w_disp_idx];
         o_exec_vj   = r_vj[w_disp_idx];
         o_exec_vk   = r_vk[w_disp_idx];
         o_exec_dest = r_dest[w_disp_idx];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_busy[i] <= 1'b0;
            r_op[i]   <= '0;
            r_vj[i]   <= '0;
            r_vk[i]   <= '0;
            r_qj[i]   <= '0;
            r_qk[i]   <= '0;
            r_rj[i]   <= 1'b0;
            r_rk[i]   <= 1'b0;
            r_dest[i] <= '0;
         end
      end else if (i_flush) begin
         // Flush wins over issue and dispatch in the same cycle.
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_busy[i] <= 1'b0;
         end
      end else begin
         r_count <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_disp_fire);
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_disp_fire && (w_disp_idx == IDX_W'(i))) begin
               r_busy[i] <= 1'b0;
            end else if (w_issue_fire && (w_alloc_idx == IDX_W'(i))) begin
               r_busy[i] <= 1'b1;
               r_op[i]   <= i_issue_op;
               r_dest[i] <= i_issue_dest;
               r_qj[i]   <= i_issue_qj;
               r_qk[i]   <= i_issue_qk;
               // Operand source: already valid, same-cycle CDB bypass, or pending.
               if (i_issue_rdy_j) begin
                  r_vj[i] <= i_issue_vj;
                  r_rj[i] <= 1'b1;
               end else begin
                  r_vj[i] <= w_byp_j[WIDTH-1:0];
                  r_rj[i] <= w_byp_j[WIDTH];
               end
               if (i_issue_rdy_k) begin
                  r_vk[i] <= i_issue_vk;
                  r_rk[i] <= 1'b1;
               end else begin
                  r_vk[i] <= w_byp_k[WIDTH-1:0];
                  r_rk[i] <= w_byp_k[WIDTH];
               end
            end else if (r_busy[i]) begin
               if (!r_rj[i] && w_snp_j[i][WIDTH]) begin
                  r_vj[i] <= w_snp_j[i][WIDTH-1:0];
                  r_rj[i] <= 1'b1;
               end
               if (!r_rk[i] && w_snp_k[i][WIDTH]) begin
                  r_vk[i] <= w_snp_k[i][WIDTH-1:0];
                  r_rk[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_param_reservation_station.sv
module tb_param_reservation_station;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TAG_W   = 3;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned NUM_CDB = 2;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

   logic                       clk;
   logic                       rst_n;
   logic                       flush;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [2:0]                 issue_op;
   logic [WIDTH-1:0]           issue_vj, issue_vk;
   logic [TAG_W-1:0]           issue_qj, issue_qk;
   logic                       issue_rdy_j, issue_rdy_k;
   logic [TAG_W-1:0]           issue_dest;
   logic [NUM_CDB-1:0]         cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
   logic [NUM_CDB*WIDTH-1:0]   cdb_data;
   logic                       exec_valid;
   logic                       exec_ready;
   logic [2:0]                 exec_op;
   logic [WIDTH-1:0]           exec_vj, exec_vk;
   logic [TAG_W-1:0]           exec_dest;
   logic [CNT_W-1:0]           count;

   int n_cmp = 0;
   int n_err = 0;

   // Expected dispatches: {op, vj, vk, dest}
   logic [3+WIDTH+WIDTH+TAG_W-1:0] exp_q[$];

   param_reservation_station #(
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .WIDTH  (WIDTH),
      .NUM_CDB(NUM_CDB)
   ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_flush      (flush),
      .i_issue_valid(issue_valid),
      .o_issue_ready(issue_ready),
      .i_issue_op   (issue_op),
      .i_issue_vj   (issue_vj),
      .i_issue_vk   (issue_vk),
      .i_issue_qj   (issue_qj),
      .i_issue_qk   (issue_qk),
      .i_issue_rdy_j(issue_rdy_j),
      .i_issue_rdy_k(issue_rdy_k),
      .i_issue_dest (issue_dest),
      .i_cdb_valid  (cdb_valid),
      .i_cdb_tag    (cdb_tag),
      .i_cdb_data   (cdb_data),
      .o_exec_valid (exec_valid),
      .i_exec_ready (exec_ready),
      .o_exec_op    (exec_op),
      .o_exec_vj    (exec_vj),
      .o_exec_vk    (exec_vk),
      .o_exec_dest  (exec_dest),
      .o_count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare the currently presented dispatch against the scoreboard head.
   task automatic pop_cmp(input string tag);
      logic [3+WIDTH+WIDTH+TAG_W-1:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed dispatch %0h expected no dispatch", tag,
                {exec_op, exec_vj, exec_vk, exec_dest});
      end else begin
         e = exp_q.pop_front();
         chk(tag, 80'({exec_op, exec_vj, exec_vk, exec_dest}), 80'(e));
      end
   endtask

   // Accept one dispatch within a bounded number of cycles.
   task automatic wait_dispatch(input string tag);
      bit found;
      found = 1'b0;
      exec_ready = 1'b1;
      for (int k = 0; k < 8 && !found; k++) begin
         if (exec_valid) begin
            found = 1'b1;
            pop_cmp(tag);
         end
         tick();
      end
      exec_ready = 1'b0;
      if (!found) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed no exec_valid expected dispatch within 8 cycles", tag);
      end
   endtask

   task automatic drive_issue(input logic [2:0] op, input logic [WIDTH-1:0] vj,
                              input logic [WIDTH-1:0] vk, input logic [TAG_W-1:0] qj,
                              input logic [TAG_W-1:0] qk, input logic rj, input logic rk,
                              input logic [TAG_W-1:0] dest);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_vj    = vj;
      issue_vk    = vk;
      issue_qj    = qj;
      issue_qk    = qk;
      issue_rdy_j = rj;
      issue_rdy_k = rk;
      issue_dest  = dest;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0;
      cdb_valid   = '0;
      cdb_tag     = '0;
      cdb_data    = '0;
      flush       = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      exec_ready = 1'b0;
      issue_op = '0; issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
      issue_rdy_j = 1'b0; issue_rdy_k = 1'b0; issue_dest = '0;
      idle_inputs();
      #1;
      chk("rst_issue_ready", 80'(issue_ready), 80'(1));
      chk("rst_exec_valid", 80'(exec_valid), 80'(0));
      chk("rst_count", 80'(count), 80'(0));
      chk("rst_exec_fields", 80'({exec_op, exec_vj, exec_vk, exec_dest}), 80'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_exec_valid", 80'(exec_valid), 80'(0));

      // Basic add with both operands ready
      drive_issue(3'd0, 32'd5, 32'd7, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
      exp_q.push_back({3'd0, 32'd5, 32'd7, 3'd2});
      tick();
      idle_inputs();
      chk("add_exec_valid", 80'(exec_valid), 80'(1));
      chk("add_count", 80'(count), 80'(1));
      wait_dispatch("add_dispatch");
      chk("add_count_after", 80'(count), 80'(0));

      // Sub waiting on tag 3, resolved by CDB channel 1
      drive_issue(3'd3, 32'd0, 32'd1, 3'd3, 3'd0, 1'b0, 1'b1, 3'd1);
      exp_q.push_back({3'd3, 32'h10, 32'd1, 3'd1});
      tick();
      idle_inputs();
      chk("sub_wait1", 80'(exec_valid), 80'(0));
      tick();
      chk("sub_wait2", 80'(exec_valid), 80'(0));
      cdb_valid = 2'b10;
      cdb_tag   = {3'd3, 3'd0};
      cdb_data  = {32'h10, 32'h0};
      #1;
      chk("sub_bcast_cycle", 80'(exec_valid), 80'(0));
      tick();
      idle_inputs();
      chk("sub_after_bcast", 80'(exec_valid), 80'(1));
      wait_dispatch("sub_dispatch");

      // Issue-time bypass on operand k
      drive_issue(3'd4, 32'd9, 32'd0, 3'd0, 3'd4, 1'b1, 1'b0, 3'd5);
      cdb_valid = 2'b01;
      cdb_tag   = {3'd7, 3'd4};
      cdb_data  = {32'h55, 32'hAA};
      exp_q.push_back({3'd4, 32'd9, 32'hAA, 3'd5});
      tick();
      idle_inputs();
      chk("byp_exec_valid", 80'(exec_valid), 80'(1));
      wait_dispatch("byp_dispatch");

      // Fill all entries, then dispatch and issue together while full
      for (int i = 0; i < 4; i++) begin
         drive_issue(3'(i + 1), 32'(16 * i + 1), 32'(16 * i + 2), 3'd0, 3'd0, 1'b1, 1'b1,
                     3'(i));
         exp_q.push_back({3'(i + 1), 32'(16 * i + 1), 32'(16 * i + 2), 3'(i)});
         tick();
      end
      idle_inputs();
      chk("full_issue_ready", 80'(issue_ready), 80'(0));
      chk("full_count", 80'(count), 80'(4));
      exec_ready = 1'b1;
      drive_issue(3'd6, 32'hDEAD, 32'hBEEF, 3'd0, 3'd0, 1'b1, 1'b1, 3'd7);
      pop_cmp("full_dispatch0");
      tick();
      exec_ready = 1'b0;
      idle_inputs();
      chk("full_count_after", 80'(count), 80'(3));
      chk("full_issue_ready_after", 80'(issue_ready), 80'(1));
      for (int i = 0; i < 3; i++) wait_dispatch("full_drain");
      chk("drain_count", 80'(count), 80'(0));

      // Two channels match the same tag: channel 0 wins
      drive_issue(3'd7, 32'd0, 32'd3, 3'd6, 3'd0, 1'b0, 1'b1, 3'd6);
      exp_q.push_back({3'd7, 32'h1, 32'd3, 3'd6});
      tick();
      idle_inputs();
      cdb_valid = 2'b11;
      cdb_tag   = {3'd6, 3'd6};
      cdb_data  = {32'h2, 32'h1};
      tick();
      idle_inputs();
      wait_dispatch("prio_dispatch");

      // Flush overrides issue and dispatch
      for (int i = 0; i < 3; i++) begin
         drive_issue(3'd2, 32'(i), 32'(i), 3'd0, 3'd0, 1'b1, 1'b1, 3'(i));
         tick();
      end
      idle_inputs();
      chk("pre_flush_count", 80'(count), 80'(3));
      flush = 1'b1;
      exec_ready = 1'b1;
      drive_issue(3'd2, 32'd9, 32'd9, 3'd0, 3'd0, 1'b1, 1'b1, 3'd4);
      tick();
      idle_inputs();
      exec_ready = 1'b0;
      chk("flush_count", 80'(count), 80'(0));
      chk("flush_exec_valid", 80'(exec_valid), 80'(0));
      chk("flush_issue_ready", 80'(issue_ready), 80'(1));

      // Asynchronous reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         drive_issue(3'd5, 32'(i), 32'(i), 3'd0, 3'd0, 1'b1, 1'b1, 3'(i));
         tick();
      end
      idle_inputs();
      chk("pre_rst_count", 80'(count), 80'(3));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", 80'(count), 80'(0));
      chk("async_rst_exec_valid", 80'(exec_valid), 80'(0));
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_issue_ready", 80'(issue_ready), 80'(1));

      // Normal operation resumes, tag 0 pending on both operands
      drive_issue(3'd1, 32'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3);
      exp_q.push_back({3'd1, 32'h77, 32'h77, 3'd3});
      tick();
      idle_inputs();
      cdb_valid = 2'b01;
      cdb_tag   = {3'd5, 3'd0};
      cdb_data  = {32'h0, 32'h77};
      tick();
      idle_inputs();
      wait_dispatch("tag0_dispatch");
      chk("queue_empty", 80'(exp_q.size()), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/param_reservation_station.md
Name: param_reservation_station

Overview:
- Parametrised successor to the single-entry reservation station unit: a DEPTH-entry, NUM_CDB-port station for the Tomasulo ALU path.
- Accepts issued ALU instructions (alu_ops opcode, two operands with ROB tags) from the decoder/issue stage.
- Snoops NUM_CDB common data buses to resolve pending operands.
- Dispatches one ready entry per cycle to the ALU via a valid/ready handshake.

Parameters:
DEPTH, 4, number of entries (2..16)
TAG_W, 3, ROB tag width in bits
WIDTH, 32, operand/data width (rv32i_word when 32)
NUM_CDB, 2, number of CDB broadcast channels snooped per cycle (1..4)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset; asynchronous, active-low
flush  input  1  synchronous clear of all entries (branch mispredict)
issue_valid  input  1  issue request
issue_ready  output  1  station can accept (registered count < DEPTH)
issue_op  input  3  alu_ops encoding
issue_vj, issue_vk  input  WIDTH each  operand values (meaningful when rdy set)
issue_qj, issue_qk  input  TAG_W each  producer tags (meaningful when rdy clear)
issue_rdy_j, issue_rdy_k  input  1 each  operand already valid
issue_dest  input  TAG_W  destination ROB tag
cdb_valid  input  NUM_CDB  per-channel broadcast valid
cdb_tag  input  NUM_CDB*TAG_W  packed tags, channel 0 in LSBs
cdb_data  input  NUM_CDB*WIDTH  packed data, channel 0 in LSBs
exec_valid  output  1  an entry is dispatching
exec_ready  input  1  ALU accepts
exec_op  output  3  dispatched opcode
exec_vj, exec_vk  output  WIDTH each  dispatched operands
exec_dest  output  TAG_W  dispatched ROB tag
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Entry state: busy, op, vj, vk, qj, qk, rj, rk, dest. Reset (rst low, async): all busy=0, count=0. Therefore issue_ready=1, exec_valid=0. Data fields are don't-care; exec_* outputs are driven 0 when exec_valid=0.
- Issue: issue_valid && issue_ready writes the lowest-index non-busy entry, setting busy=1 at the next edge.
- issue_ready derives from registered count only. When full it stays 0 even if a dispatch fires in the same cycle (no full bypass).
- Issue-time CDB bypass: if an operand arrives with rdy=0 and any cdb_valid[c] with cdb_tag[c]==q in the same cycle, store cdb_data[c] and set r=1.
- CDB snoop: every cycle, for each busy entry and each operand with r=0, a matching valid channel captures data and sets r=1 at the next edge. If several channels match, the lowest channel index wins.
- Readiness: an entry is ready when busy && rj && rk. Readiness is registered, so a snooped operand makes its entry dispatchable one cycle after the broadcast, never in the broadcast cycle.
- Dispatch: combinational select of the lowest-index ready entry. exec_valid=1 iff any ready entry exists; exec_* carry that entry's fields.
- On exec_valid && exec_ready the entry is freed (busy=0) at the edge. exec_ready may depend on exec_valid; exec_* must stay stable while exec_valid && !exec_ready, unless a lower-index entry becomes ready (allowed; the ALU latches on handshake only).
- The same cycle may contain an issue, a dispatch, and CDB captures on other entries. count updates as count + issue_fire - dispatch_fire.
- A freed entry cannot be reallocated in the same cycle it is freed; allocation uses the registered busy vector.
- flush=1: at the next edge all busy=0 and count=0. flush overrides issue and dispatch in that cycle. The dispatch handshake is ignored by the station; the ROB discards the result.
- Reset asserted mid-operation clears everything immediately. There are no pending outputs after reset.
- Tag 0 is a legal tag; only the rdy flags decide validity.

Test Plan:
- Reset then idle -> issue_ready=1, exec_valid=0, count=0. Issue op=alu_add, vj=5, vk=7, both rdy, dest=2 -> next cycle exec_valid=1, exec_vj=5, exec_vk=7, exec_dest=2. With exec_ready=1 -> count returns to 0.
- Issue alu_sub with qj=3 (rdy_j=0), vk=1. After 2 cycles broadcast cdb_valid=2'b10, tag ch1=3, data=0x10 -> exec_valid rises exactly one cycle later with exec_vj=0x10.
- Issue with qk=4 in the same cycle as CDB ch0 tag=4 data=0xAA -> entry ready next cycle with exec_vk=0xAA (bypass).
- Fill 4 entries with exec_ready=0 -> issue_ready=0, count=4. Raise exec_ready and issue_valid together for one cycle -> entry 0 dispatched, issue not accepted, count=3.
- Both CDB channels broadcast the same tag with data 0x1 (ch0) and 0x2 (ch1) -> captured operand=0x1.
- 3 busy entries, assert flush with issue_valid=1 and exec_ready=1 -> next cycle count=0, exec_valid=0. Repeat with rst pulsed low mid-cycle -> immediate clear.
